// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for the ALU divide handshake.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             in_reset,
   input  logic             in_div_reset,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               sign_q_q, sign_q_d;
   logic               sign_r_q, sign_r_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   abs_dividend;
   logic [WIDTH-1:0]   abs_divisor;
   logic [WIDTH-1:0]   q_signed;
   logic [WIDTH-1:0]   r_signed;

   // Unsigned magnitudes; the most negative value maps onto itself.
   assign abs_dividend = in_dividend[WIDTH-1]
                       ? ('0 - in_dividend) : in_dividend;
   assign abs_divisor  = in_divisor[WIDTH-1]
                       ? ('0 - in_divisor) : in_divisor;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      r_d      = r_q;
      d_d      = d_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      dz_d     = dz_q;
      busy_d   = busy_q;
      done_d   = done_q;
      trial    = '0;
      if (in_div_reset) begin
         q_d      = abs_dividend;
         d_d      = abs_divisor;
         r_d      = '0;
         sign_q_d = in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
         sign_r_d = in_dividend[WIDTH-1];
         dz_d     = (in_divisor == '0);
         cnt_d    = '0;
         state_d  = S_CALC;
         busy_d   = 1'b1;
         done_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end
            S_CALC: begin
               trial = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
               if (!trial[WIDTH]) begin
                  r_d = trial[WIDTH-1:0];
                  q_d = {q_q[WIDTH-2:0], 1'b1};
               end else begin
                  r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                  q_d = {q_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + ONE;
               if (cnt_d == LAST) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            S_DONE: begin
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         q_q      <= '0;
         r_q      <= '0;
         d_q      <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         r_q      <= r_d;
         d_q      <= d_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign q_signed = sign_q_q ? ('0 - q_q) : q_q;
   // With a zero divisor every step succeeds, so R ends as |dividend|.
   assign r_signed = sign_r_q ? ('0 - r_q) : r_q;

   assign out_quotient    = !done_q ? '0
                          : dz_q    ? '1
                          : q_signed;
   assign out_remainder   = done_q ? r_signed : '0;
   assign out_busy        = busy_q;
   assign out_done        = done_q;
   assign out_div_by_zero = done_q & dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an
// arithmetic reference model.
module tb_seq_divider;

   logic        clk;
   logic        in_reset;
   logic        in_div_reset;
   logic [31:0] in_dividend;
   logic [31:0] in_divisor;
   logic [31:0] out_quotient;
   logic [31:0] out_remainder;
   logic        out_busy;
   logic        out_done;
   logic        out_div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk             (clk),
      .in_reset        (in_reset),
      .in_div_reset    (in_div_reset),
      .in_dividend     (in_dividend),
      .in_divisor      (in_divisor),
      .out_quotient    (out_quotient),
      .out_remainder   (out_remainder),
      .out_busy        (out_busy),
      .out_done        (out_done),
      .out_div_by_zero (out_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic, truncated to 32 bits.
   task automatic model(input  logic [31:0] a,
                        input  logic [31:0] b,
                        output logic [31:0] q,
                        output logic [31:0] r,
                        output logic        dz);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else begin
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
         dz = 1'b0;
      end
   endtask

   task automatic start_op(input logic [31:0] a,
                           input logic [31:0] b);
      @(negedge clk);
      in_dividend  = a;
      in_divisor   = b;
      in_div_reset = 1'b1;
      @(posedge clk);
      #1;
      in_div_reset = 1'b0;
      check("start_busy", {31'd0, out_busy}, 32'd1);
      check("start_done", {31'd0, out_done}, 32'd0);
   endtask

   task automatic finish_op(input logic [31:0] a,
                            input logic [31:0] b,
                            input bit          scramble);
      logic [31:0] eq, er;
      logic        edz;
      model(a, b, eq, er, edz);
      if (scramble) begin
         in_dividend = $urandom;
         in_divisor  = $urandom;
      end
      for (int e = 1; e < 32; e++) begin
         @(posedge clk);
         #1;
         check("calc_busy", {31'd0, out_busy}, 32'd1);
         check("calc_done", {31'd0, out_done}, 32'd0);
      end
      @(posedge clk);
      #1;
      check("end_done", {31'd0, out_done}, 32'd1);
      check("end_busy", {31'd0, out_busy}, 32'd0);
      check("quotient", out_quotient, eq);
      check("remainder", out_remainder, er);
      check("div_by_zero", {31'd0, out_div_by_zero}, {31'd0, edz});
      in_dividend = $urandom;
      in_divisor  = $urandom;
      repeat (3) @(posedge clk);
      #1;
      check("hold_done", {31'd0, out_done}, 32'd1);
      check("hold_q", out_quotient, eq);
      check("hold_r", out_remainder, er);
   endtask

   task automatic run_div(input logic [31:0] a,
                          input logic [31:0] b);
      start_op(a, b);
      finish_op(a, b, 1'b1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      in_reset     = 1'b0;
      in_div_reset = 1'b0;
      in_dividend  = 32'd0;
      in_divisor   = 32'd0;
      #12;
      check("rst_q", out_quotient, 32'd0);
      check("rst_r", out_remainder, 32'd0);
      check("rst_busy", {31'd0, out_busy}, 32'd0);
      check("rst_done", {31'd0, out_done}, 32'd0);
      check("rst_dz", {31'd0, out_div_by_zero}, 32'd0);
      @(negedge clk);
      in_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_done", {31'd0, out_done}, 32'd0);

      run_div(32'd100, 32'd7);
      check("q_100_7", out_quotient, 32'd14);
      check("r_100_7", out_remainder, 32'd2);
      run_div(-32'sd100, 32'd7);
      check("q_m100_7", out_quotient, 32'hFFFF_FFF2);
      check("r_m100_7", out_remainder, 32'hFFFF_FFFE);
      run_div(32'd100, -32'sd7);
      check("q_100_m7", out_quotient, 32'hFFFF_FFF2);
      check("r_100_m7", out_remainder, 32'd2);
      run_div(32'h8000_0000, 32'hFFFF_FFFF);
      check("q_ovf", out_quotient, 32'h8000_0000);
      check("r_ovf", out_remainder, 32'd0);
      check("dz_ovf", {31'd0, out_div_by_zero}, 32'd0);
      run_div(32'hFFFF_FFFF, 32'h8000_0000);
      check("q_m1_min", out_quotient, 32'd0);
      check("r_m1_min", out_remainder, 32'hFFFF_FFFF);
      run_div(32'd1234, 32'd0);
      check("q_dz", out_quotient, 32'hFFFF_FFFF);
      check("r_dz", out_remainder, 32'd1234);
      check("dz_flag", {31'd0, out_div_by_zero}, 32'd1);
      run_div(32'd81, 32'd9);
      check("dz_clear", {31'd0, out_div_by_zero}, 32'd0);

      start_op(32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      start_op(32'd81, 32'd9);
      finish_op(32'd81, 32'd9, 1'b1);
      check("q_restart", out_quotient, 32'd9);
      check("r_restart", out_remainder, 32'd0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i[0]) rb = rb >> $urandom_range(0, 28);
         run_div(ra, rb);
      end

      start_op(32'd5000, 32'd13);
      repeat (15) @(posedge clk);
      #2;
      in_reset = 1'b0;
      #1;
      check("arst_busy", {31'd0, out_busy}, 32'd0);
      check("arst_done", {31'd0, out_done}, 32'd0);
      check("arst_q", out_quotient, 32'd0);
      check("arst_r", out_remainder, 32'd0);
      check("arst_dz", {31'd0, out_div_by_zero}, 32'd0);
      @(negedge clk);
      in_reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_done", {31'd0, out_done}, 32'd0);
      check("post_rst_busy", {31'd0, out_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit integer divider in the ALU; the responder side of the control unit's divide handshake.
- The control unit pulses in_div_reset for one cycle with the dividend on in_dividend (Y register) and the divisor on in_divisor (bus, Rb).
- The control unit then holds its div4 state and Z write for a fixed 34-cycle window. This block must present quotient/remainder before that window closes.
- Z captures quotient in LO (to LO register) and remainder in HI (to HI register).

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_div_reset  input  1  synchronous start/restart pulse, active-high.
- in_dividend  input  WIDTH  signed dividend; sampled only on a start edge.
- in_divisor  input  WIDTH  signed divisor; sampled only on a start edge.
- out_quotient  output  WIDTH  signed quotient, truncated toward zero.
- out_remainder  output  WIDTH  signed remainder; its sign follows the dividend.
- out_busy  output  1  high while iterating.
- out_done  output  1  high when results are valid; held until the next start or reset.
- out_div_by_zero  output  1  divisor was zero; valid when out_done=1.

Behaviour:
- Reset (in_reset=0, async):
  - state=IDLE, counter=0, all internal registers 0.
  - out_quotient=0, out_remainder=0, out_busy=0, out_done=0, out_div_by_zero=0.
  - Reset mid-operation aborts the operation immediately; no partial results are kept.
- States: IDLE, CALC, DONE.
- Start edge (in_div_reset=1 at rising clk, in any state, including mid-CALC) = edge 0:
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register. Absolute values are unsigned 32-bit, so 0x80000000 stays 0x80000000.
  - Latch sign_q = dividend[31] xor divisor[31], sign_r = dividend[31], dz = (divisor==0).
  - Clear the partial remainder and set counter=0.
  - Go to CALC: out_busy=1, out_done=0.
- CALC, edges 1..WIDTH (one restoring step per edge):
  - Form {R,Q} shifted left 1 into a WIDTH+1-bit trial: T = {R,Q[31]} - D.
  - If T is non-negative: R=T[WIDTH-1:0], Q bit0=1. Else: R={R,Q[31]} truncated, Q bit0=0.
  - counter += 1.
  - On the edge where counter reaches WIDTH: go to DONE, out_busy=0, out_done=1.
- Latency:
  - out_done is asserted after edge 32 following the start edge.
  - Results are stable from that point until the next start edge.
  - This leaves at least one cycle of margin inside the control unit's 34-cycle wait.
- Outputs (combinational from registers, valid only when out_done=1):
  - out_quotient = sign_q ? -Q : Q.
  - out_remainder = sign_r ? -R : R.
  - When dz=1, the outputs are forced: out_quotient=0xFFFFFFFF, out_remainder=dividend as latched (sign restored), out_div_by_zero=1.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, no flag (two's-complement wrap).
- in_div_reset held high for several cycles: each edge restarts; the count begins from the last high edge.
- DONE persists; no auto-return to IDLE. Only a start edge or reset leaves DONE.
- IDLE and DONE ignore operand changes.
- in_div_reset while in_reset=0: ignored; reset dominates.

Test Plan:
- 100/7: pulse start → out_busy 1 for 32 cycles, out_done rises exactly after edge 32, q=14 (0x0000000E), r=2.
- -100/7 → q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2). Then 100/-7 → q=-14, r=2.
- 0x80000000/0xFFFFFFFF → q=0x80000000, r=0, div_by_zero=0. Then 0xFFFFFFFF/0x80000000 → q=0, r=0xFFFFFFFF.
- 1234/0 → out_done after 32 cycles, q=0xFFFFFFFF, r=1234, out_div_by_zero=1. Next valid divide clears the flag.
- Restart at edge 10 of a 1000/3 run with operands 81/9:
  - out_done stays 0 until 32 edges after the restart.
  - Then q=9, r=0.
  - Changing operands after the start edge has no effect.
- Assert in_reset=0 at edge 15 of a run → all outputs 0 immediately, asynchronously. After release, no done without a new start.
